// File: rtl/spectrum_rx_pkg.sv
// Shared types and constants for the spectrum frame receiver.
package spectrum_rx_pkg;

  // Parser states
  typedef enum logic [2:0] {
    StHunt0,
    StHunt1,
    StPayload,
    StCheck,
    StWaitSwap
  } rx_state_e;

  localparam logic [7:0] HDR0_DEF = 8'hA5;
  localparam logic [7:0] HDR1_DEF = 8'h5A;
  localparam int unsigned CSUM_W = 8;
  localparam int unsigned BYTE_W = 8;

  // Saturating 8-bit increment for the error counter
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spectrum_frame_rx_if.sv
// Byte-stream valid/ready interface from the UART receiver.
interface spectrum_frame_rx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bin_bank_ram.sv
// Double-buffered bin store: simple dual-port RAM, registered read, no reset (block RAM).
module bin_bank_ram
  import spectrum_rx_pkg::*;
#(
  parameter int unsigned NUM_BINS = 64,
  localparam int unsigned ADDR_W = $clog2(NUM_BINS)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic              rbank_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  // Sized to the full {bank, index} space so every address is in range
  logic [BYTE_W-1:0] mem [2**(ADDR_W+1)];

  // Write port and registered read port
  always_ff @(posedge clk_i) begin
    if (we_i) mem[{wbank_i, waddr_i}] <= wdata_i;
    rdata_o <= mem[{rbank_i, raddr_i}];
  end

endmodule

// File: rtl/spectrum_frame_rx.sv
// Framed FFT magnitude packet parser with double-buffered bin store.
// Optional macro FRAME_TIMEOUT_EN adds an inter-byte timeout that aborts a partial frame.
module spectrum_frame_rx
  import spectrum_rx_pkg::*;
#(
  parameter int unsigned NUM_BINS       = 64,
  parameter logic [7:0]  HDR0           = HDR0_DEF,
  parameter logic [7:0]  HDR1           = HDR1_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  localparam int unsigned ADDR_W        = $clog2(NUM_BINS)
) (
  input  logic                clk,
  input  logic                reset,
  spectrum_frame_rx_if.slave  in_if,
  input  logic                frame_sync,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [7:0]          rd_data,
  output logic                frame_done,
  output logic                front_bank,
  output logic [7:0]          err_count
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_BINS - 1);

  rx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CSUM_W-1:0] sum_q, sum_d;
  logic              front_q, front_d;
  logic              have_q, have_d;
  logic              done_q, done_d;
  logic [7:0]        err_q, err_d;
  logic              ready_q;
  logic              rd_ok_q;
  logic [7:0]        ram_rdata;
  logic              accept, wr_en, timeout;

  assign in_if.in_ready = ready_q && (state_q != StWaitSwap);
  assign accept         = in_if.in_valid && in_if.in_ready;

`ifdef FRAME_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;

  // Idle counter runs only while a frame is partially received
  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (state_q inside {StHunt1, StPayload, StCheck} && !accept) begin
      if (idle_q == 32'(TIMEOUT_CYCLES - 1)) timeout = 1'b1;
      else idle_d = idle_q + 32'd1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Parser next state, checksum and bank swap control
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    front_d = front_q;
    have_d  = have_q;
    err_d   = err_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      StHunt0: if (accept && in_if.in_data == HDR0) state_d = StHunt1;
      StHunt1: begin
        if (accept) begin
          if (in_if.in_data == HDR1) begin
            state_d = StPayload;
            idx_d   = '0;
            sum_d   = '0;
          end else if (in_if.in_data != HDR0) begin
            state_d = StHunt0;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          wr_en = 1'b1;
          sum_d = sum_q + in_if.in_data;
          if (idx_q == LastIdx) state_d = StCheck;
          else idx_d = idx_q + 1'b1;
        end
      end
      StCheck: begin
        if (accept) begin
          if (in_if.in_data == sum_q) begin
            state_d = StWaitSwap;
          end else begin
            err_d   = sat_inc(err_q);
            state_d = StHunt0;
          end
        end
      end
      StWaitSwap: begin
        if (frame_sync) begin
          front_d = ~front_q;
          have_d  = 1'b1;
          done_d  = 1'b1;
          state_d = StHunt0;
        end
      end
      default: state_d = StHunt0;
    endcase
    // Timeout only fires on cycles with no accepted byte, so it never races the case above
    if (timeout) begin
      state_d = StHunt0;
      err_d   = sat_inc(err_q);
      idx_d   = '0;
      sum_d   = '0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHunt0;
      idx_q   <= '0;
      sum_q   <= '0;
      front_q <= 1'b0;
      have_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      ready_q <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      front_q <= front_d;
      have_q  <= have_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
      rd_ok_q <= have_q && (32'(rd_addr) < NUM_BINS);
    end
  end

  bin_bank_ram #(
    .NUM_BINS (NUM_BINS)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .wbank_i (~front_q),
    .waddr_i (idx_q),
    .wdata_i (in_if.in_data),
    .rbank_i (front_q),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign rd_data    = rd_ok_q ? ram_rdata : 8'h00;
  assign frame_done = done_q;
  assign front_bank = front_q;
  assign err_count  = err_q;

endmodule
